// File: rtl/imm_extend_stage_pkg.sv
// Shared types for the decode->execute immediate stage: format selector and
// the datapath-width legality check.
package imm_extend_stage_pkg;

    typedef enum logic [2:0] {
        IMM_I     = 3'd0,
        IMM_S     = 3'd1,
        IMM_B     = 3'd2,
        IMM_J     = 3'd3,
        IMM_U     = 3'd4,
        IMM_ZIMM  = 3'd5,
        IMM_SHAMT = 3'd6,
        IMM_RSVD  = 3'd7
    } imm_src_t;

    localparam int INSTR_LSB = 7;

    function automatic bit xlen_legal(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/imm_extend_stage_if.sv
// Upstream (instruction in) and downstream (immediate out) handshakes of the stage.
interface imm_extend_stage_if
    import imm_extend_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [31:INSTR_LSB]  in_instr;
    imm_src_t             in_imm_src;
    logic [TAG_W-1:0]     in_tag;

    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      out_imm;
    logic [TAG_W-1:0]     out_tag;
    logic                 out_illegal;

    modport master (
        output in_valid, in_instr, in_imm_src, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_tag, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_imm_src, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_tag, out_illegal
    );
endinterface

// File: rtl/imm_extend_stage_imm_gen.sv
// Combinational RV immediate format mux; sign bit is always instr[31].
module imm_extend_stage_imm_gen
    import imm_extend_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:INSTR_LSB] instr,
    input  imm_src_t            src,
    output logic [XLEN-1:0]     imm,
    output logic                illegal
);

    // Sign-extended formats preload the sign across XLEN, then overwrite the low field.
    always_comb begin
        imm     = '0;
        illegal = 1'b0;
        case (src)
            IMM_I: begin
                imm        = {XLEN{instr[31]}};
                imm[11:0]  = instr[31:20];
            end
            IMM_S: begin
                imm        = {XLEN{instr[31]}};
                imm[11:0]  = {instr[31:25], instr[11:7]};
            end
            IMM_B: begin
                imm        = {XLEN{instr[31]}};
                imm[12:0]  = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            IMM_J: begin
                imm        = {XLEN{instr[31]}};
                imm[20:0]  = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            IMM_U: begin
                imm        = {XLEN{instr[31]}};
                imm[31:0]  = {instr[31:12], 12'h000};
            end
            IMM_ZIMM: begin
                imm[4:0]   = instr[19:15];
            end
            IMM_SHAMT: begin
                if (XLEN == 64) imm[5:0] = instr[25:20];
                else            imm[4:0] = instr[24:20];
            end
            IMM_RSVD: begin
                illegal    = 1'b1;
            end
            default: begin
                illegal    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_extend_stage.sv
// Registered valid/ready immediate stage: imm_gen feeding a main output register
// backed by one skid entry, so in_ready is a flop and never sees out_ready.
module imm_extend_stage
    import imm_extend_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic              clk,
    input  logic              rstn,
    imm_extend_stage_if.slave bus
);

    if (!xlen_legal(XLEN)) begin : g_xlen_chk
        $error("imm_extend_stage: XLEN must be 32 or 64");
    end

    logic [XLEN-1:0]  gen_imm;
    logic             gen_illegal;

    logic             main_valid;
    logic [XLEN-1:0]  main_imm;
    logic [TAG_W-1:0] main_tag;
    logic             main_illegal;

    logic             skid_valid;
    logic [XLEN-1:0]  skid_imm;
    logic [TAG_W-1:0] skid_tag;
    logic             skid_illegal;

    logic             accept;
    logic             drain;

    imm_extend_stage_imm_gen #(.XLEN(XLEN)) u_gen (
        .instr   (bus.in_instr),
        .src     (bus.in_imm_src),
        .imm     (gen_imm),
        .illegal (gen_illegal)
    );

    assign accept = bus.in_valid && !skid_valid;
    assign drain  = main_valid && bus.out_ready;

    // With skid full, in_ready is low, so a skid->main move never coincides with an accept.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            main_valid   <= 1'b0;
            main_imm     <= '0;
            main_tag     <= '0;
            main_illegal <= 1'b0;
            skid_valid   <= 1'b0;
            skid_imm     <= '0;
            skid_tag     <= '0;
            skid_illegal <= 1'b0;
        end else if (drain && skid_valid) begin
            main_imm     <= skid_imm;
            main_tag     <= skid_tag;
            main_illegal <= skid_illegal;
            skid_valid   <= 1'b0;
        end else if (accept && (drain || !main_valid)) begin
            main_valid   <= 1'b1;
            main_imm     <= gen_imm;
            main_tag     <= bus.in_tag;
            main_illegal <= gen_illegal;
        end else if (accept) begin
            skid_valid   <= 1'b1;
            skid_imm     <= gen_imm;
            skid_tag     <= bus.in_tag;
            skid_illegal <= gen_illegal;
        end else if (drain) begin
            main_valid   <= 1'b0;
        end
    end

    assign bus.in_ready    = !skid_valid;
    assign bus.out_valid   = main_valid;
    assign bus.out_imm     = main_imm;
    assign bus.out_tag     = main_tag;
    assign bus.out_illegal = main_illegal;

endmodule

// File: tb/tb_imm_extend_stage.sv
// Bench for imm_extend_stage: XLEN=32 and XLEN=64 instances share one stimulus,
// a scoreboard queue holds model results for every accepted beat.
module tb_imm_extend_stage;
    import imm_extend_stage_pkg::*;

    typedef struct {
        logic [31:0] i32;
        logic [63:0] i64;
        logic [7:0]  tag;
        logic        ill;
    } exp_t;

    logic clk;
    logic rstn;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    exp_t        mon_e;
    logic [31:0] mon_ins;
    logic [63:0] mon_m32;
    logic [63:0] mon_m64;
    logic [31:0] rnd;
    int          beats;
    int          ncyc;
    bit          acc;

    imm_extend_stage_if #(.XLEN(32), .TAG_W(8)) bus32 ();
    imm_extend_stage_if #(.XLEN(64), .TAG_W(8)) bus64 ();

    assign bus64.in_valid   = bus32.in_valid;
    assign bus64.in_instr   = bus32.in_instr;
    assign bus64.in_imm_src = bus32.in_imm_src;
    assign bus64.in_tag     = bus32.in_tag;
    assign bus64.out_ready  = bus32.out_ready;

    imm_extend_stage #(.XLEN(32), .TAG_W(8)) dut32 (.clk(clk), .rstn(rstn), .bus(bus32));
    imm_extend_stage #(.XLEN(64), .TAG_W(8)) dut64 (.clk(clk), .rstn(rstn), .bus(bus64));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [31:0] ins, input imm_src_t src, input bit is64);
        logic signed [63:0] v;
        case (src)
            IMM_I:     v = 64'($signed(ins[31:20]));
            IMM_S:     v = 64'($signed({ins[31:25], ins[11:7]}));
            IMM_B:     v = 64'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            IMM_J:     v = 64'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            IMM_U:     v = 64'($signed({ins[31:12], 12'h000}));
            IMM_ZIMM:  v = {59'd0, ins[19:15]};
            IMM_SHAMT: v = is64 ? {58'd0, ins[25:20]} : {59'd0, ins[24:20]};
            default:   v = 64'd0;
        endcase
        return is64 ? v : {32'd0, v[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: push on accept, compare front while out_valid, pop on transfer.
    always @(negedge clk) begin
        if (rstn) begin
            if (bus32.in_valid && bus32.in_ready) begin
                mon_ins = {bus32.in_instr, 7'h00};
                mon_m32 = model(mon_ins, bus32.in_imm_src, 1'b0);
                mon_m64 = model(mon_ins, bus32.in_imm_src, 1'b1);
                sb.push_back('{mon_m32[31:0], mon_m64, bus32.in_tag, bus32.in_imm_src == IMM_RSVD});
            end
            chk("valid64_vs_32", bus64.out_valid, bus32.out_valid);
            chk("ready64_vs_32", bus64.in_ready, bus32.in_ready);
            if (bus32.out_valid) begin
                chk("beat_has_expect", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    mon_e = sb[0];
                    chk("sb_imm32", bus32.out_imm, mon_e.i32);
                    chk("sb_imm64", bus64.out_imm, mon_e.i64);
                    chk("sb_tag", bus32.out_tag, mon_e.tag);
                    chk("sb_tag64", bus64.out_tag, mon_e.tag);
                    chk("sb_illegal", bus32.out_illegal, mon_e.ill);
                    chk("sb_illegal64", bus64.out_illegal, mon_e.ill);
                    if (bus32.out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    task automatic drive(input logic [31:0] ins, input imm_src_t src, input logic [7:0] tag);
        bus32.in_valid   = 1'b1;
        bus32.in_instr   = ins[31:7];
        bus32.in_imm_src = src;
        bus32.in_tag     = tag;
    endtask

    task automatic send(input logic [31:0] ins, input imm_src_t src, input logic [7:0] tag);
        bit a;
        int n;
        a = 1'b0;
        n = 0;
        drive(ins, src, tag);
        while (!a && n < 50) begin
            @(negedge clk);
            a = bus32.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        bus32.in_valid = 1'b0;
        chk("send_accept", a, 1);
    endtask

    task automatic send_expect(input string tag, input logic [31:0] ins, input imm_src_t src,
                               input logic [63:0] e32, input logic [63:0] e64, input logic eill);
        send(ins, src, 8'(checks));
        @(negedge clk);
        chk({tag, "_valid"}, bus32.out_valid, 1);
        chk({tag, "_imm32"}, bus32.out_imm, e32);
        chk({tag, "_imm64"}, bus64.out_imm, e64);
        chk({tag, "_illegal"}, bus32.out_illegal, eill);
        @(posedge clk);
        #1;
    endtask

    task automatic drain_all(input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || bus32.out_valid) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_in_budget", n < budget, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn             = 1'b0;
        bus32.in_valid   = 1'b0;
        bus32.in_instr   = '0;
        bus32.in_imm_src = IMM_I;
        bus32.in_tag     = '0;
        bus32.out_ready  = 1'b1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", bus32.out_valid, 0);
        chk("rst_in_ready", bus32.in_ready, 1);
        chk("rst_out_imm", bus32.out_imm, 0);
        chk("rst_out_tag", bus32.out_tag, 0);
        chk("rst_out_illegal", bus32.out_illegal, 0);
        chk("rst_out_valid64", bus64.out_valid, 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Formats, one beat each, out_ready=1
        send_expect("fmt_i",     32'hFFF00093, IMM_I,     64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        send_expect("fmt_s",     32'hFE20AE23, IMM_S,     64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        send_expect("fmt_b",     32'hFE000CE3, IMM_B,     64'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 1'b0);
        send_expect("fmt_u",     32'h123452B7, IMM_U,     64'h12345000, 64'h0000000012345000, 1'b0);
        send_expect("fmt_j",     32'h001000EF, IMM_J,     64'h00000800, 64'h0000000000000800, 1'b0);
        send_expect("fmt_u_neg", 32'h800002B7, IMM_U,     64'h80000000, 64'hFFFFFFFF80000000, 1'b0);
        send_expect("fmt_shamt", 32'h03F01013, IMM_SHAMT, 64'h0000001F, 64'h000000000000003F, 1'b0);
        send_expect("fmt_zimm",  32'h000F8073, IMM_ZIMM,  64'h0000001F, 64'h000000000000001F, 1'b0);
        send_expect("fmt_zimm_hi", 32'hFFFFF073, IMM_ZIMM, 64'h0000001F, 64'h000000000000001F, 1'b0);
        send_expect("fmt_rsvd",  32'hFFFFFFFF, IMM_RSVD,  64'h00000000, 64'h0000000000000000, 1'b1);
        drain_all(20);

        // Backpressure: tags 1,2 accepted, 3 stalls, then drain in order without gaps
        bus32.out_ready = 1'b0;
        drive(32'hFFF00093, IMM_I, 8'd1);
        @(negedge clk);
        chk("bp_ready_beat1", bus32.in_ready, 1);
        @(posedge clk);
        #1;
        drive(32'hFE20AE23, IMM_S, 8'd2);
        @(negedge clk);
        chk("bp_ready_beat2", bus32.in_ready, 1);
        @(posedge clk);
        #1;
        drive(32'h123452B7, IMM_U, 8'd3);
        @(negedge clk);
        chk("bp_ready_beat3", bus32.in_ready, 0);
        chk("bp_hold_tag1", bus32.out_tag, 1);
        @(posedge clk);
        #1;
        bus32.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_drain1_valid", bus32.out_valid, 1);
        chk("bp_drain1_tag", bus32.out_tag, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_drain2_valid", bus32.out_valid, 1);
        chk("bp_drain2_tag", bus32.out_tag, 2);
        chk("bp_ready_reopen", bus32.in_ready, 1);
        @(posedge clk);
        #1;
        bus32.in_valid = 1'b0;
        @(negedge clk);
        chk("bp_drain3_valid", bus32.out_valid, 1);
        chk("bp_drain3_tag", bus32.out_tag, 3);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_no_dup", bus32.out_valid, 0);
        @(posedge clk);
        #1;

        // Streaming with random traffic and random backpressure
        beats = 0;
        ncyc  = 0;
        while (beats < 100 && ncyc < 2000) begin
            rnd = $urandom();
            bus32.out_ready  = ($urandom_range(0, 3) != 0);
            bus32.in_valid   = ($urandom_range(0, 3) != 0);
            bus32.in_instr   = rnd[31:7];
            bus32.in_imm_src = imm_src_t'(3'($urandom_range(0, 7)));
            bus32.in_tag     = 8'($urandom());
            @(negedge clk);
            acc = bus32.in_valid && bus32.in_ready;
            @(posedge clk);
            #1;
            if (acc) beats++;
            ncyc++;
        end
        bus32.in_valid  = 1'b0;
        bus32.out_ready = 1'b1;
        chk("stream_beats", beats, 100);
        drain_all(50);

        // Reset with both entries full
        bus32.out_ready = 1'b0;
        drive(32'hFE000CE3, IMM_B, 8'hA1);
        @(posedge clk);
        #1;
        drive(32'h001000EF, IMM_J, 8'hA2);
        @(posedge clk);
        #1;
        bus32.in_valid = 1'b0;
        @(negedge clk);
        chk("full_out_valid", bus32.out_valid, 1);
        chk("full_in_ready", bus32.in_ready, 0);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        sb.delete();
        #1;
        chk("midrst_out_valid", bus32.out_valid, 0);
        chk("midrst_in_ready", bus32.in_ready, 1);
        chk("midrst_out_valid64", bus64.out_valid, 0);
        @(negedge clk);
        chk("midrst_hold_valid", bus32.out_valid, 0);
        chk("midrst_hold_ready", bus32.in_ready, 1);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        bus32.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_no_stale", bus32.out_valid, 0);
        end
        @(posedge clk);
        #1;
        send_expect("post_rst_i", 32'h7FF00093, IMM_I, 64'h000007FF, 64'h00000000000007FF, 1'b0);
        drain_all(20);

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
